// File: rtl/synch_pkg.sv
// -----------------------------------------------------------------------------
// synch_pkg
// Shared constants and helpers for the multi-channel synchronizer/filter.
//   SYNCH_STAGES_DEF : default synchronizer depth
//   clog2()          : ceiling log2, usable in constant expressions
//   cnt_width()      : filter counter width, never narrower than one bit
// -----------------------------------------------------------------------------
package synch_pkg;

    localparam int SYNCH_STAGES_DEF = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // FILT_CYCLES=1 gives clog2()=0; keep a 1-bit counter so the vector stays legal.
    function automatic int cnt_width(input int filt_cycles);
        return (clog2(filt_cycles) < 1) ? 1 : clog2(filt_cycles);
    endfunction

endpackage

// File: rtl/synch_filter_chan.sv
// -----------------------------------------------------------------------------
// synch_filter_chan
// One channel: STAGES-deep synchronizer chain, stability filter and
// registered edge pulses.
//   clk, rst_n   : clock, async active-low reset
//   async_bit    : asynchronous input (sampled only by chain[0])
//   filt_en      : 0 bypasses the stability filter
//   sync_raw     : last chain stage
//   sync_out     : filtered level
//   rise, fall   : one-cycle pulses, aligned with the sync_out change
//   rise_nxt,
//   fall_nxt     : next-state values of rise/fall, for the shared CHG flop
// -----------------------------------------------------------------------------
module synch_filter_chan
    import synch_pkg::*;
#(
    parameter int   STAGES      = SYNCH_STAGES_DEF,
    parameter int   FILT_CYCLES = 4,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_bit,
    input  logic filt_en,
    output logic sync_raw,
    output logic sync_out,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);

    localparam int            CW       = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              out_d;
    logic              filt_en_q;
    logic              bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_BIT}};
        end else begin
            chain <= {chain[STAGES-2:0], async_bit};
        end
    end

    assign sync_raw = chain[STAGES-1];
    assign bypass   = !filt_en || (FILT_CYCLES == 1);

    always_comb begin
        out_d = sync_out;
        cnt_d = cnt_q;
        if (sync_raw == sync_out) begin
            cnt_d = '0;
        end else if (bypass) begin
            out_d = sync_raw;
            cnt_d = '0;
        end else if (filt_en != filt_en_q) begin
            // Filter just re-enabled: start qualification from scratch.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            out_d = sync_raw;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise_nxt = out_d & ~sync_out;
    assign fall_nxt = ~out_d & sync_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_out  <= RST_BIT;
            cnt_q     <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            filt_en_q <= 1'b1;
        end else begin
            sync_out  <= out_d;
            cnt_q     <= cnt_d;
            rise      <= rise_nxt;
            fall      <= fall_nxt;
            filt_en_q <= filt_en;
        end
    end

endmodule

// File: rtl/synch_filter_multi.sv
// -----------------------------------------------------------------------------
// synch_filter_multi
// WIDTH independent synchronizer + glitch-filter channels with edge pulses.
//   CLK, RST_N : clock, async active-low reset (release synchronous to CLK)
//   ASYNC_IN   : asynchronous inputs, one bit per channel
//   FILT_EN    : quasi-static; 0 makes SYNC_OUT follow SYNC_RAW one cycle later
//   SYNC_RAW   : synchronized, unfiltered levels
//   SYNC_OUT   : filtered levels
//   RISE, FALL : one-cycle pulses when a SYNC_OUT bit changes
//   CHG        : high in any cycle where a RISE or FALL bit is high
// -----------------------------------------------------------------------------
module synch_filter_multi
    import synch_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               STAGES      = SYNCH_STAGES_DEF,
    parameter int               FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] ASYNC_IN,
    input  logic             FILT_EN,
    output logic [WIDTH-1:0] SYNC_RAW,
    output logic [WIDTH-1:0] SYNC_OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHG
);

    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        synch_filter_chan #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RST_BIT     (RST_VAL[i])
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RST_N),
            .async_bit (ASYNC_IN[i]),
            .filt_en   (FILT_EN),
            .sync_raw  (SYNC_RAW[i]),
            .sync_out  (SYNC_OUT[i]),
            .rise      (RISE[i]),
            .fall      (FALL[i]),
            .rise_nxt  (rise_nxt[i]),
            .fall_nxt  (fall_nxt[i])
        );
    end

    // Built from the channels' next-state pulses so CHG lines up with RISE/FALL.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CHG <= 1'b0;
        end else begin
            CHG <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_synch_filter_multi.sv
module tb_synch_filter_multi;

    logic       CLK;
    logic       RST_N;
    logic [3:0] ASYNC_IN;
    logic       FILT_EN;
    logic [3:0] SYNC_RAW;
    logic [3:0] SYNC_OUT;
    logic [3:0] RISE;
    logic [3:0] FALL;
    logic       CHG;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         at;
        string      tag;
        bit         chk_raw;
        logic [3:0] raw;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } exp_t;

    exp_t sb[$];

    synch_filter_multi #(
        .WIDTH       (4),
        .STAGES      (3),
        .FILT_CYCLES (4),
        .RST_VAL     (4'h0)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ASYNC_IN (ASYNC_IN),
        .FILT_EN  (FILT_EN),
        .SYNC_RAW (SYNC_RAW),
        .SYNC_OUT (SYNC_OUT),
        .RISE     (RISE),
        .FALL     (FALL),
        .CHG      (CHG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected output snapshot d cycles after the current one (sorted insert).
    task automatic push(input int d, input string tag, input bit cr, input logic [3:0] raw,
                        input logic [3:0] out, input logic [3:0] rise,
                        input logic [3:0] fall, input logic chg);
        exp_t e;
        int   pos;
        e.at = cyc + d; e.tag = tag; e.chk_raw = cr; e.raw = raw;
        e.out = out; e.rise = rise; e.fall = fall; e.chg = chg;
        pos = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].at > e.at) begin
                pos = k;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Scheduled cycles get a full compare; every other cycle must be pulse-free.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            if (e.chk_raw) chk({e.tag, ".raw"}, 32'(SYNC_RAW), 32'(e.raw));
            chk({e.tag, ".out"},  32'(SYNC_OUT), 32'(e.out));
            chk({e.tag, ".rise"}, 32'(RISE),     32'(e.rise));
            chk({e.tag, ".fall"}, 32'(FALL),     32'(e.fall));
            chk({e.tag, ".chg"},  32'(CHG),      32'(e.chg));
        end else begin
            chk("quiet.rise", 32'(RISE), 32'h0);
            chk("quiet.fall", 32'(FALL), 32'h0);
            chk("quiet.chg",  32'(CHG),  32'h0);
        end
    end

    initial begin
        RST_N    = 1'b0;
        ASYNC_IN = 4'hF;
        FILT_EN  = 1'b1;

        // Reset with inputs already high, then release.
        step(3);
        chk("rst.raw", 32'(SYNC_RAW), 32'h0);
        chk("rst.out", 32'(SYNC_OUT), 32'h0);
        chk("rst.rf",  32'({RISE, FALL}), 32'h0);
        chk("rst.chg", 32'(CHG), 32'h0);
        RST_N = 1'b1;
        push(2, "rel_e2", 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(3, "rel_e3", 1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        push(6, "rel_e6", 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(7, "rel_e7", 0, 4'h0, 4'hF, 4'hF, 4'h0, 1'b1);
        push(8, "rel_e8", 0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
        step(10);

        // 3-cycle low glitch on ch0 is rejected.
        ASYNC_IN = 4'hE;
        push(3, "gl3_a", 1, 4'hE, 4'hF, 4'h0, 4'h0, 1'b0);
        push(5, "gl3_b", 1, 4'hE, 4'hF, 4'h0, 4'h0, 1'b0);
        push(6, "gl3_c", 1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        step(3);
        ASYNC_IN = 4'hF;
        step(8);

        // 4-cycle low on ch0 qualifies, then the return qualifies too.
        ASYNC_IN = 4'hE;
        push(6,  "gl4_a",    1, 4'hE, 4'hF, 4'h0, 4'h0, 1'b0);
        push(7,  "gl4_fall", 1, 4'hF, 4'hE, 4'h0, 4'h1, 1'b1);
        push(11, "gl4_rise", 0, 4'h0, 4'hF, 4'h1, 4'h0, 1'b1);
        step(4);
        ASYNC_IN = 4'hF;
        step(12);

        // Chatter on ch1 every 2 cycles, then settle low.
        push(20, "chat_mid", 0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
        push(26, "chat_pre", 1, 4'hD, 4'hF, 4'h0, 4'h0, 1'b0);
        push(27, "chat_edg", 0, 4'h0, 4'hD, 4'h0, 4'h2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            ASYNC_IN[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        ASYNC_IN[1] = 1'b0;
        step(12);

        // Bypass: ch2 low, then a single-cycle high pulse.
        FILT_EN = 1'b0;
        step(2);
        ASYNC_IN[2] = 1'b0;
        push(3, "byp_pre",  1, 4'h9, 4'hD, 4'h0, 4'h0, 1'b0);
        push(4, "byp_fall", 0, 4'h0, 4'h9, 4'h0, 4'h4, 1'b1);
        step(6);
        ASYNC_IN[2] = 1'b1;
        push(3, "pls_raw",  1, 4'hD, 4'h9, 4'h0, 4'h0, 1'b0);
        push(4, "pls_rise", 1, 4'h9, 4'hD, 4'h4, 4'h0, 1'b1);
        push(5, "pls_fall", 0, 4'h0, 4'h9, 4'h0, 4'h4, 1'b1);
        step(1);
        ASYNC_IN[2] = 1'b0;
        step(6);
        FILT_EN = 1'b1;
        step(4);

        // Reset while ch3 is mid-qualification (count 2).
        ASYNC_IN = 4'h1;
        push(3, "mid_raw", 1, 4'h1, 4'h9, 4'h0, 4'h0, 1'b0);
        push(4, "mid_cnt", 0, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0);
        step(5);
        RST_N = 1'b0;
        #1;
        chk("mid_rst.out", 32'(SYNC_OUT), 32'h0);
        chk("mid_rst.raw", 32'(SYNC_RAW), 32'h0);
        chk("mid_rst.rf",  32'({RISE, FALL}), 32'h0);
        chk("mid_rst.chg", 32'(CHG), 32'h0);
        ASYNC_IN = 4'h9;
        step(2);
        RST_N = 1'b1;
        push(3, "rel2_raw", 1, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0);
        push(6, "rel2_pre", 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(7, "rel2_edg", 0, 4'h0, 4'h9, 4'h9, 4'h0, 1'b1);
        step(10);

        // Simultaneous ch0 rise and ch3 fall.
        ASYNC_IN = 4'h8;
        push(7, "sim_prep", 0, 4'h0, 4'h8, 4'h0, 4'h1, 1'b1);
        step(10);
        ASYNC_IN = 4'h1;
        push(7, "sim_edg",  0, 4'h0, 4'h1, 4'h1, 4'h8, 1'b1);
        push(8, "sim_post", 0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        step(12);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
